icb_sram_ctrl: RTL
==================

Name: icb_sram_ctrl

Overview:
- ICB-slave sequencer that feeds the perip_SRAM pin driver.
- Accepts 32-bit ICB read/write commands and splits each into timed 16-bit asynchronous SRAM accesses.
- Drives the mem_address / mem_wren / mem_rden / data_in strobes with programmable wait states; partial-halfword writes use read-modify-write.
- Sits between the e203 peripheral ICB fabric and perip_SRAM.

Parameters:
- AW, 20, SRAM halfword address width; must match perip_SRAM AW.
- WAIT_CYC, 1, extra strobe cycles per access; strobe length = WAIT_CYC+1 cycles; range 0..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_addr  in  32  byte address; [AW:2] selects the word.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte write mask.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_rdata  out  32  read data.
- icb_rsp_err  out  1  misaligned-address error.
- mem_address  out  AW  halfword address to perip_SRAM.
- mem_wren  out  1  write strobe, active high.
- mem_rden  out  1  read strobe, active high.
- data_in  out  16  write halfword to perip_SRAM.
- data_out  in  16  read halfword from perip_SRAM.

Behaviour:
- Reset: state IDLE; mem_wren=0, mem_rden=0, mem_address=0, data_in=0, icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0. Strobes drop asynchronously with RST.
- Reset mid-operation: the access is abandoned and no response is issued.
- All outputs are registered except icb_cmd_ready, which equals (state==IDLE).
- Command handshake is on valid&ready. The command is latched at that edge.
- If icb_cmd_addr[1:0]!=0: no SRAM access; icb_rsp_err=1 and rdata=0 on the next cycle.
- Halfword mapping: halfword h=0 is addr {icb_cmd_addr[AW:2],1'b0} and carries bits [15:0]; h=1 is {..,1'b1} and carries bits [31:16].
- Access sequence = SETUP(1) -> STROBE(WAIT_CYC+1) -> HOLD(1), i.e. WAIT_CYC+3 cycles:
  - SETUP: address and data_in updated, both strobes low.
  - STROBE: mem_rden or mem_wren high; address and data stable.
  - HOLD: strobes low; address and data unchanged.
- Reads: data_out is sampled at the last STROBE cycle.
- Access list per command, in order h=0 then h=1:
  - Read: RD0, RD1; the mask is ignored.
  - Write, mask pair 11: WRh.
  - Write, mask pair 00: skipped.
  - Write, partial mask pair: RDh then WRh. WRh data = the mask-merged wdata bytes over the read halfword.
- States: IDLE -> SETUP -> STROBE -> HOLD -> (next access SETUP | RSP). An empty access list (write with wmask 0000, or error) goes IDLE -> RSP.
- RSP: icb_rsp_valid=1 and held with stable rdata/err until icb_rsp_ready. The handshake edge returns to IDLE, so the next command is accepted at the earliest one cycle later.
- Latency: rsp_valid rises N*(WAIT_CYC+3)+1 cycles after the cmd handshake edge, where N = number of accesses; an empty list gives 1.
- icb_rsp_rdata = {RD1 data, RD0 data} for reads and 0 for writes. icb_rsp_err=0 except on misalignment.
- mem_wren and mem_rden are never high together.
- The wait counter is width 4 and saturates at WAIT_CYC. No wrap hazards.

Optional Feature:
- Macro ICB_SRAM_RMW_EN.
- Defined: partial-halfword writes perform read-modify-write as above.
- Undefined: no RD phase for writes. A mask pair with any bit set writes the full halfword from wdata, so a partial mask pair behaves like 11. The merge datapath is removed.

Test Plan:
- WAIT_CYC=1; read addr 0x0000_0008 with SRAM model holding 0x0004=0xBEEF, 0x0005=0xDEAD -> RD strobes on addresses 4 then 5, each 2 cycles; rsp_valid 9 cycles after handshake; rdata=0xDEADBEEF, err=0.
- Write addr 0x10, wdata 0x12345678, mask 1111 -> wren on addr 8 with data_in 0x5678, then addr 9 with 0x1234; rden never high; rsp_valid after 9 cycles.
- RMW_EN; SRAM addr 8 = 0xAAAA; write addr 0x10, wdata 0x0000_00CC, mask 0001 -> RD8 then WR8 with data_in 0xAACC; addr 9 untouched; rsp_valid after 9 cycles.
- Write mask 0000 -> no strobes; rsp_valid next cycle. Read addr 0x2 -> no strobes; rsp_valid next cycle with err=1, rdata=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, cmd_ready=0. A new cmd_valid is not accepted until one cycle after the rsp handshake.
- Assert RST during STROBE of a write -> mem_wren=0 immediately, no response, cmd_ready=1 after release, next read completes correctly.

Source files
------------

// File: rtl/icb_sram_ctrl.sv
// rtl/icb_sram_ctrl.sv - ICB slave sequencing 32-bit commands into timed 16-bit async SRAM accesses
// Optional ICB_SRAM_RMW_EN: partial-halfword writes become read-modify-write.
module icb_sram_ctrl #(
  parameter int AW       = 20,
  parameter int WAIT_CYC = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [31:0]   icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [31:0]   icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic [AW-1:0] mem_address,
  output logic          mem_wren,
  output logic          mem_rden,
  output logic [15:0]   data_in,
  input  logic [15:0]   data_out
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RSP} state_t;
  localparam logic [3:0] W_LAST = 4'(WAIT_CYC);

  state_t        r_state, w_state_nxt;
  logic          r_h, r_op_rd, r_read;
  logic [AW-2:0] r_word;
  logic [31:0]   r_wdata, r_rdacc;
  logic [3:0]    r_wmask, r_wcnt;
  logic          w_nxt_h, w_nxt_rd, w_hs, w_misal, w_last;
  logic          w_src_read, w_has0, w_has1, w_frd0, w_frd1;
  logic [AW-2:0] w_src_word;
  logic [31:0]   w_src_wdata;
  logic [3:0]    w_src_wmask;
  logic [15:0]   w_hw_sel, w_wr_hw;
  logic          w_unused;

  assign icb_cmd_ready = (r_state == S_IDLE);
  assign w_hs          = icb_cmd_valid & icb_cmd_ready;
  assign w_misal       = |icb_cmd_addr[1:0];
  assign w_last        = (r_wcnt == W_LAST);
  assign w_unused      = ^icb_cmd_addr[31:AW+1];

  // In IDLE the access plan is taken straight from the command bus; afterwards from the latch.
  assign w_src_read  = icb_cmd_ready ? icb_cmd_read : r_read;
  assign w_src_word  = icb_cmd_ready ? icb_cmd_addr[AW:2] : r_word;
  assign w_src_wdata = icb_cmd_ready ? icb_cmd_wdata : r_wdata;
  assign w_src_wmask = icb_cmd_ready ? icb_cmd_wmask : r_wmask;
  assign w_has0      = w_src_read | (|w_src_wmask[1:0]);
  assign w_has1      = w_src_read | (|w_src_wmask[3:2]);
  assign w_hw_sel    = w_nxt_h ? w_src_wdata[31:16] : w_src_wdata[15:0];

`ifdef ICB_SRAM_RMW_EN
  logic [15:0] r_rd_hw;
  logic [1:0]  w_m_sel;
  assign w_m_sel = w_nxt_h ? w_src_wmask[3:2] : w_src_wmask[1:0];
  // A partial mask pair has exactly one bit set, hence the xor.
  assign w_frd0  = w_src_read | (^w_src_wmask[1:0]);
  assign w_frd1  = w_src_read | (^w_src_wmask[3:2]);
  assign w_wr_hw = {w_m_sel[1] ? w_hw_sel[15:8] : r_rd_hw[15:8],
                    w_m_sel[0] ? w_hw_sel[7:0]  : r_rd_hw[7:0]};
`else
  assign w_frd0  = w_src_read;
  assign w_frd1  = w_src_read;
  assign w_wr_hw = w_hw_sel;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_nxt_h     = r_h;
    w_nxt_rd    = r_op_rd;
    case (r_state)
      S_IDLE: if (icb_cmd_valid) begin
        if (w_misal) w_state_nxt = S_RSP;
        else if (w_has0) begin
          w_state_nxt = S_SETUP; w_nxt_h = 1'b0; w_nxt_rd = w_frd0;
        end else if (w_has1) begin
          w_state_nxt = S_SETUP; w_nxt_h = 1'b1; w_nxt_rd = w_frd1;
        end else w_state_nxt = S_RSP;
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: if (w_last) w_state_nxt = S_HOLD;
      S_HOLD: begin
        // A read on a write command is the first half of a merge: write the same halfword next.
        if (r_op_rd && !r_read) begin
          w_state_nxt = S_SETUP; w_nxt_rd = 1'b0;
        end else if (!r_h && w_has1) begin
          w_state_nxt = S_SETUP; w_nxt_h = 1'b1; w_nxt_rd = w_frd1;
        end else w_state_nxt = S_RSP;
      end
      S_RSP:    if (icb_rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE; r_h <= 1'b0; r_op_rd <= 1'b0; r_read <= 1'b0;
      r_word <= '0; r_wdata <= '0; r_wmask <= '0; r_wcnt <= '0; r_rdacc <= '0;
      mem_address <= '0; mem_wren <= 1'b0; mem_rden <= 1'b0; data_in <= '0;
      icb_rsp_valid <= 1'b0; icb_rsp_rdata <= '0; icb_rsp_err <= 1'b0;
`ifdef ICB_SRAM_RMW_EN
      r_rd_hw <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_nxt_h;
      r_op_rd <= w_nxt_rd;
      if (w_hs) begin
        r_word <= icb_cmd_addr[AW:2]; r_read <= icb_cmd_read;
        r_wdata <= icb_cmd_wdata; r_wmask <= icb_cmd_wmask;
        icb_rsp_err <= w_misal; icb_rsp_rdata <= '0;
      end
      if (w_state_nxt == S_SETUP) begin
        mem_address <= {w_src_word, w_nxt_h};
        if (!w_nxt_rd) data_in <= w_wr_hw;
      end
      mem_rden <= (w_state_nxt == S_STROBE) && w_nxt_rd;
      mem_wren <= (w_state_nxt == S_STROBE) && !w_nxt_rd;
      if (r_state == S_STROBE && !w_last) r_wcnt <= r_wcnt + 4'd1;
      else r_wcnt <= '0;
      if (r_state == S_STROBE && w_last && r_op_rd) begin
        if (r_h) r_rdacc[31:16] <= data_out;
        else     r_rdacc[15:0]  <= data_out;
`ifdef ICB_SRAM_RMW_EN
        r_rd_hw <= data_out;
`endif
      end
      if (r_state == S_HOLD && w_state_nxt == S_RSP) icb_rsp_rdata <= r_read ? r_rdacc : 32'd0;
      icb_rsp_valid <= (w_state_nxt == S_RSP);
      if (r_state == S_RSP && icb_rsp_ready) icb_rsp_err <= 1'b0;
    end
  end

endmodule
